data_memory: RTL and testbench

//  Byte-addressable, little-endian data memory for the single-cycle RISC-V datapath (load/store unit).

---
 rtl/data_memory.sv | 85 ++++++++
 tb/tb_data_memory.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressable little-endian load/store memory: zero-latency combinational reads,
// writes commit on the rising clk edge, no backpressure; async reset clears every byte.
module data_memory #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] DataRd
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          unused_addr;

  assign word_idx    = Address[AW+1:2];
  assign lane        = Address[1:0];
  assign unused_addr = ^Address[31:AW+2];

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = Address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    DataRd = 32'h0;
    case (DMCtrl)
      3'b000:  DataRd = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  DataRd = {{16{rd_half[15]}}, rd_half};
      3'b010:  DataRd = rd_word;
      3'b100:  DataRd = {24'h0, rd_byte};
      3'b101:  DataRd = {16'h0, rd_half};
      default: DataRd = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the destination.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    case (DMCtrl)
      3'b000: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{DataWr[7:0]}};
      end
      3'b001: begin
        wr_be   = Address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{DataWr[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_data = DataWr;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (DMWr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory against a flat byte-array reference model.
module tb_data_memory;

  localparam int DEPTH_WORDS = 1024;
  localparam int BYTES       = 4 * DEPTH_WORDS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] DataWr = 32'h0;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = 3'b010;
  logic [31:0] DataRd;

  data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Address(Address),
    .DataWr (DataWr),
    .DMWr   (DMWr),
    .DMCtrl (DMCtrl),
    .DataRd (DataRd)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [BYTES];
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          passes = 0;

  function automatic void model_clear();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h0;
  endfunction

  function automatic int model_base(input logic [31:0] a);
    return int'(a % 32'(BYTES));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] c);
    int          base;
    int          hb;
    int          wb;
    logic [7:0]  b;
    logic [15:0] h;
    base = model_base(a);
    hb   = base - (base % 2);
    wb   = base - (base % 4);
    b    = ref_mem[base];
    h    = {ref_mem[hb + 1], ref_mem[hb]};
    case (c)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {ref_mem[wb + 3], ref_mem[wb + 2], ref_mem[wb + 1], ref_mem[wb]};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
    int base;
    int hb;
    int wb;
    base = model_base(a);
    hb   = base - (base % 2);
    wb   = base - (base % 4);
    case (c)
      3'b000: ref_mem[base] = d[7:0];
      3'b001: begin
        ref_mem[hb]     = d[7:0];
        ref_mem[hb + 1] = d[15:8];
      end
      3'b010: begin
        ref_mem[wb]     = d[7:0];
        ref_mem[wb + 1] = d[15:8];
        ref_mem[wb + 2] = d[23:16];
        ref_mem[wb + 3] = d[31:24];
      end
      default: ;
    endcase
  endfunction

  // One bus cycle: drive at negedge, queue the expected read, then commit the model at posedge.
  task automatic op(input logic rst, input logic [2:0] ctrl, input logic [31:0] addr,
                    input logic [31:0] wdat, input logic wr, input bit chk, input string nm);
    @(negedge clk);
    rst_n   = rst;
    DMCtrl  = ctrl;
    Address = addr;
    DataWr  = wdat;
    DMWr    = wr;
    if (!rst) model_clear();
    if (chk) begin
      exp_q.push_back(model_read(addr, ctrl));
      name_q.push_back(nm);
    end
    @(posedge clk);
    if (wr && rst_n) model_write(addr, ctrl, wdat);
  endtask

  initial begin : monitor
    logic [31:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        checks++;
        if (DataRd === exp) passes++;
        else $display("FAIL %s: DataRd=%h expected %h (Address=%h DMCtrl=%b)", nm, DataRd, exp, Address, DMCtrl);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] addr;
    logic [2:0]  ctrl;
    model_clear();

    op(1'b0, 3'b010, 32'd0,         32'h0, 1'b0, 1, "reset_hold_lw0");
    op(1'b1, 3'b010, 32'd0,         32'h0, 1'b0, 1, "reset_lw0");
    op(1'b1, 3'b010, 32'd12,        32'h0, 1'b0, 1, "reset_lw12");
    op(1'b1, 3'b010, 32'(BYTES-4),  32'h0, 1'b0, 1, "reset_lwtop");

    op(1'b1, 3'b010, 32'd12, 32'h0000FFFC, 1'b1, 1, "sw12_before_edge");
    op(1'b1, 3'b010, 32'd12, 32'h0,        1'b0, 1, "lw12_after_sw");

    op(1'b1, 3'b010, 32'd8, 32'h11223344, 1'b1, 0, "");
    op(1'b1, 3'b000, 32'd9, 32'h000000AB, 1'b1, 0, "");
    op(1'b1, 3'b010, 32'd8, 32'h0,        1'b0, 1, "lw8_after_sb");
    op(1'b1, 3'b000, 32'd9, 32'h0,        1'b0, 1, "lb9");
    op(1'b1, 3'b100, 32'd9, 32'h0,        1'b0, 1, "lbu9");

    op(1'b1, 3'b010, 32'd4, 32'hCAFE1234, 1'b1, 0, "");
    op(1'b1, 3'b001, 32'd6, 32'h55558001, 1'b1, 0, "");
    op(1'b1, 3'b001, 32'd6, 32'h0,        1'b0, 1, "lh6");
    op(1'b1, 3'b101, 32'd6, 32'h0,        1'b0, 1, "lhu6");
    op(1'b1, 3'b001, 32'd7, 32'h0,        1'b0, 1, "lh7_aligned");
    op(1'b1, 3'b010, 32'd4, 32'h0,        1'b0, 1, "lw4_after_sh");

    op(1'b1, 3'b010, 32'd12, 32'hDEADBEEF, 1'b0, 1, "dmwr0_cycle");
    op(1'b1, 3'b010, 32'd12, 32'h0,        1'b0, 1, "dmwr0_unchanged");
    op(1'b1, 3'b011, 32'd12, 32'hDEADBEEF, 1'b1, 1, "ctrl011_read0");
    op(1'b1, 3'b010, 32'd12, 32'h0,        1'b0, 1, "ctrl011_nowrite");
    op(1'b1, 3'b110, 32'd8,  32'h0,        1'b0, 1, "ctrl110_read0");
    op(1'b1, 3'b111, 32'd8,  32'h0,        1'b0, 1, "ctrl111_read0");
    op(1'b1, 3'b010, 32'(BYTES+12), 32'h0, 1'b0, 1, "alias_lw12");
    op(1'b1, 3'b010, 32'd15, 32'h0,        1'b0, 1, "lw15_aligned");

    for (int n = 0; n < 400; n++) begin
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'(BYTES - 64);
      if ($urandom_range(0, 3) == 0) addr = addr + (32'($urandom_range(1, 1023)) << 12);
      ctrl = 3'($urandom_range(0, 7));
      op(1'b1, ctrl, addr, $urandom, 1'($urandom_range(0, 1)), 1, "random");
    end

    op(1'b1, 3'b010, 32'd20, 32'h89ABCDEF, 1'b1, 0, "");
    op(1'b0, 3'b010, 32'd20, 32'h0,        1'b0, 1, "midrun_reset_lw20");
    op(1'b0, 3'b010, 32'd24, 32'h13572468, 1'b1, 1, "reset_with_write");
    op(1'b1, 3'b010, 32'd24, 32'h0,        1'b0, 1, "write_lost_lw24");
    op(1'b1, 3'b010, 32'd12, 32'h0,        1'b0, 1, "midrun_reset_lw12");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
